serial_subtractor_ctrl: RTL and testbench

Bit-serial subtraction engine that computes `a - b - bin` over `WIDTH`-bit operands. It uses one full-subtractor cell per clock, with the bit count set by a counter and the borrow fed back through a register. Operands are accepted on a start/ready handshake, and the result is reported with a one-cycle done pulse. It sits beside the combinational subtractor cells as the area-minimal, multi-cycle alternative for wide operands.

---
 rtl/serial_subtractor_ctrl.sv | 115 +++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
`timescale 1ns/1ps
// serial_subtractor_ctrl: bit-serial a - b - bin, one full-subtractor cell per clock.
// Ports: clk, rst (sync, active-high), start/ready handshake, a, b, bin in;
//   busy, done pulse, diff, borrow out; ovf out only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_nxt;
  logic             last;
  logic [WIDTH-1:0] res_nxt;

  assign d       = a_sh[0] ^ b_sh[0] ^ br;
  assign br_nxt  = (~a_sh[0] & b_sh[0])
                 | (~(a_sh[0] ^ b_sh[0]) & br);
  assign res_nxt = {d, res_sh[WIDTH-1:1]};
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= res_nxt;
          br     <= br_nxt;
          if (last) begin
            // cnt holds at WIDTH-1 rather than wrapping
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            diff   <= res_nxt;
            borrow <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // borrow into MSB vs borrow out of MSB
            ovf    <= br ^ br_nxt;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
`timescale 1ns/1ps
// tb_serial_subtractor_ctrl: scoreboard bench, WIDTH=8 directed+random
// and WIDTH=4 exhaustive, against an arithmetic reference model.
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst, start, bin, ready, busy, done, borrow, ovf;
  logic [7:0] a, b, diff;
  logic       rst4, start4, bin4, ready4, busy4, done4, borrow4, ovf4;
  logic [3:0] a4, b4, diff4;

  serial_subtractor_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .bin(bin),
    .ready(ready), .busy(busy), .done(done),
    .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_subtractor_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst4), .start(start4),
    .a(a4), .b(b4), .bin(bin4),
    .ready(ready4), .busy(busy4), .done(done4),
    .diff(diff4), .borrow(borrow4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf  = 1'b0;
  assign ovf4 = 1'b0;
`endif

  typedef struct {
    int d;
    int br;
    int ov;
    int cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string n, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, expv);
    end
  endtask

  task automatic fail(string n);
    checks++;
    errors++;
    $display("FAIL %s", n);
  endtask

  // Plain integer arithmetic: a - b - bin, unsigned and signed views
  function automatic exp_t model(int w, int av, int bv, int biv);
    exp_t e;
    int r, sa, sb, sr, half;
    half = 1 << (w - 1);
    r    = av - bv - biv;
    sa   = (av >= half) ? av - (1 << w) : av;
    sb   = (bv >= half) ? bv - (1 << w) : bv;
    sr   = sa - sb - biv;
    e.d  = r & ((1 << w) - 1);
    e.br = (r < 0) ? 1 : 0;
    e.ov = (sr < -half || sr > half - 1) ? 1 : 0;
    e.cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin : mon8
    exp_t e;
    if (done) begin
      if (q8.size() == 0) fail("done8_unexpected");
      else begin
        e = q8.pop_front();
        chk("diff8", diff, e.d);
        chk("borrow8", borrow, e.br);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf8", ovf, e.ov);
`endif
        chk("lat8", cyc - e.cyc, 8);
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) fail("done4_unexpected");
      else begin
        e = q4.pop_front();
        chk("diff4", diff4, e.d);
        chk("borrow4", borrow4, e.br);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf4", ovf4, e.ov);
`endif
        chk("lat4", cyc - e.cyc, 4);
      end
    end
  end

  int last_acc = 0;

  // Called #1 after an edge; returns #1 after the accepting edge
  task automatic issue8(int av, int bv, int biv, bit hold);
    exp_t e;
    int n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!ready) begin
      fail("ready8_timeout");
      return;
    end
    a = av[7:0]; b = bv[7:0]; bin = biv[0];
    start = 1'b1;
    @(posedge clk); #1;
    e = model(8, av, bv, biv);
    e.cyc = cyc;
    last_acc = cyc;
    q8.push_back(e);
    if (!hold) start = 1'b0;
  endtask

  task automatic issue4(int av, int bv, int biv);
    exp_t e;
    int n = 0;
    while (!ready4 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!ready4) begin
      fail("ready4_timeout");
      return;
    end
    a4 = av[3:0]; b4 = bv[3:0]; bin4 = biv[0];
    start4 = 1'b1;
    @(posedge clk); #1;
    e = model(4, av, bv, biv);
    e.cyc = cyc;
    q4.push_back(e);
  endtask

  task automatic run8();
    int prev;
    issue8(8'h5A, 8'h23, 0, 0);
    issue8(8'h00, 8'h01, 0, 0);
    issue8(8'h10, 8'h10, 1, 0);
    issue8(8'h80, 8'h01, 0, 0);
    issue8(8'h7F, 8'hFF, 0, 0);
    // start pulse with new operands mid-RUN must be ignored
    issue8(8'h33, 8'h11, 1, 0);
    repeat (2) begin @(posedge clk); #1; end
    a = 8'hFF; b = 8'h00; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // start held high: back-to-back every WIDTH+2 cycles
    issue8(8'h01, 8'h02, 0, 1);
    for (int i = 0; i < 4; i++) begin
      prev = last_acc;
      issue8($urandom_range(255), $urandom_range(255),
             $urandom_range(1), 1);
      chk("period", last_acc - prev, 10);
    end
    start = 1'b0;
    // reset during the 4th RUN cycle aborts the operation
    issue8(8'hC3, 8'h3C, 1, 0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q8.delete();
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    repeat (12) begin @(posedge clk); #1; end
    issue8(8'h5A, 8'h23, 0, 0);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(2)) begin @(posedge clk); #1; end
      issue8($urandom_range(255), $urandom_range(255),
             $urandom_range(1), 0);
    end
  endtask

  task automatic run4();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          issue4(x, y, c);
    start4 = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_diff", diff, 0);
    chk("reset_borrow", borrow, 0);
    chk("reset_ready4", ready4, 1);
    rst = 1'b0;
    rst4 = 1'b0;
    fork
      run8();
      run4();
    join
    n = 0;
    while ((q8.size() != 0 || q4.size() != 0) && n < 200) begin
      @(posedge clk); n++;
    end
    if (q8.size() != 0 || q4.size() != 0) fail("drain_timeout");
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
